// File: rtl/tt_pfd_tdc_if.sv
// Bundle of the phase-detector clock inputs, detector outputs and scan pins.
// The master side drives the asynchronous clocks and scan inputs; the slave side is the detector.
interface tt_pfd_tdc_if #(
   parameter int ERR_W = 8
);
   logic             i_clk_ref;
   logic             i_clk_div;
   logic             o_up;
   logic             o_down;
   logic [ERR_W-1:0] o_err;
   logic             o_err_valid;
   logic             o_slip;
   logic             o_lock;
   logic             i_scan_en;
   logic             i_scan_in;
   logic             o_scan_out;

   modport master (
      output i_clk_ref, i_clk_div, i_scan_en, i_scan_in,
      input  o_up, o_down, o_err, o_err_valid, o_slip, o_lock, o_scan_out
   );

   modport slave (
      input  i_clk_ref, i_clk_div, i_scan_en, i_scan_in,
      output o_up, o_down, o_err, o_err_valid, o_slip, o_lock, o_scan_out
   );
endinterface

// File: rtl/tt_pfd_tdc.sv
// Digital PFD with saturating time-to-digital phase error, slip flag and scan chain.
// Optional lock detector enabled by defining TT_PFD_LOCK_DET_EN.
module tt_pfd_tdc #(
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8,
   parameter int LOCK_TOL    = 1,
   parameter int LOCK_COUNT  = 16
) (
   input  logic        i_clk_gen,
   input  logic        i_rst_n,
   tt_pfd_tdc_if.slave pfd_if
);

   localparam int CH_W  = SYNC_STAGES + 1;
   localparam int CNT_W = ERR_W - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   // Index 0 is the first synchroniser stage, CH_W-1 the history flop.
   logic [CH_W-1:0]  ref_ch_q, ref_ch_d;
   logic [CH_W-1:0]  div_ch_q, div_ch_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             up_q, up_d;
   logic             down_q, down_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             err_valid_q, err_valid_d;
   logic             slip_q, slip_d;

   logic             ref_edge_s, div_edge_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [ERR_W-1:0] pos_err_s, neg_err_s;

   // Synchronisers double as the scan chain: ref chain feeds the div chain in scan mode.
   always_comb begin
      if (pfd_if.i_scan_en) begin
         ref_ch_d = {ref_ch_q[CH_W-2:0], pfd_if.i_scan_in};
         div_ch_d = {div_ch_q[CH_W-2:0], ref_ch_q[CH_W-1]};
      end else begin
         ref_ch_d = {ref_ch_q[CH_W-2:0], pfd_if.i_clk_ref};
         div_ch_d = {div_ch_q[CH_W-2:0], pfd_if.i_clk_div};
      end
   end

   assign ref_edge_s = ~pfd_if.i_scan_en & ref_ch_q[CH_W-2] & ~ref_ch_q[CH_W-1];
   assign div_edge_s = ~pfd_if.i_scan_en & div_ch_q[CH_W-2] & ~div_ch_q[CH_W-1];
   assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   assign pos_err_s  = {1'b0, cnt_q};
   assign neg_err_s  = {ERR_W{1'b0}} - pos_err_s;

   // Next-state and strobe logic of the UP/DOWN/IDLE machine.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      err_valid_d = 1'b0;
      slip_d      = 1'b0;
      if (pfd_if.i_scan_en) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ref_edge_s && div_edge_s) begin
                  err_valid_d = 1'b1;
                  err_d       = {ERR_W{1'b0}};
               end else if (ref_edge_s) begin
                  state_d = ST_UP;
                  cnt_d   = CNT_ONE;
               end else if (div_edge_s) begin
                  state_d = ST_DOWN;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_UP: begin
               if (ref_edge_s && div_edge_s) begin
                  err_valid_d = 1'b1;
                  err_d       = pos_err_s;
                  cnt_d       = CNT_ONE;
               end else if (div_edge_s) begin
                  state_d     = ST_IDLE;
                  err_valid_d = 1'b1;
                  err_d       = pos_err_s;
               end else if (ref_edge_s) begin
                  slip_d = 1'b1;
                  cnt_d  = cnt_inc_s;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            ST_DOWN: begin
               if (ref_edge_s && div_edge_s) begin
                  err_valid_d = 1'b1;
                  err_d       = neg_err_s;
                  cnt_d       = CNT_ONE;
               end else if (ref_edge_s) begin
                  state_d     = ST_IDLE;
                  err_valid_d = 1'b1;
                  err_d       = neg_err_s;
               end else if (div_edge_s) begin
                  slip_d = 1'b1;
                  cnt_d  = cnt_inc_s;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      up_d   = (state_d == ST_UP);
      down_d = (state_d == ST_DOWN);
   end

   // State, counter, synchroniser and output registers.
   always_ff @(posedge i_clk_gen) begin
      if (!i_rst_n) begin
         ref_ch_q    <= {CH_W{1'b0}};
         div_ch_q    <= {CH_W{1'b0}};
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         up_q        <= 1'b0;
         down_q      <= 1'b0;
         err_q       <= {ERR_W{1'b0}};
         err_valid_q <= 1'b0;
         slip_q      <= 1'b0;
      end else begin
         ref_ch_q    <= ref_ch_d;
         div_ch_q    <= div_ch_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         up_q        <= up_d;
         down_q      <= down_d;
         err_q       <= err_d;
         err_valid_q <= err_valid_d;
         slip_q      <= slip_d;
      end
   end

`ifdef TT_PFD_LOCK_DET_EN
   localparam int LC_W = $clog2(LOCK_COUNT + 1);
   localparam logic [LC_W-1:0]         LC_MAX = LC_W'(LOCK_COUNT);
   localparam logic signed [ERR_W-1:0] TOL_P  = ERR_W'(LOCK_TOL);
   localparam logic signed [ERR_W-1:0] TOL_N  = -TOL_P;

   logic [LC_W-1:0] lcnt_q, lcnt_d;
   logic            lock_q, lock_d;
   logic            in_tol_s;

   assign in_tol_s = ($signed(err_q) <= TOL_P) && ($signed(err_q) >= TOL_N);

   // Lock qualification works on the registered strobes, so it reacts one cycle later.
   always_comb begin
      lcnt_d = lcnt_q;
      lock_d = lock_q;
      if (pfd_if.i_scan_en) begin
         lcnt_d = lcnt_q;
      end else if (slip_q || (err_valid_q && !in_tol_s)) begin
         lcnt_d = {LC_W{1'b0}};
         lock_d = 1'b0;
      end else if (err_valid_q) begin
         lcnt_d = (lcnt_q == LC_MAX) ? lcnt_q : lcnt_q + LC_W'(1);
         lock_d = (lcnt_d == LC_MAX);
      end else begin
         lcnt_d = lcnt_q;
      end
   end

   // Lock counter registers.
   always_ff @(posedge i_clk_gen) begin
      if (!i_rst_n) begin
         lcnt_q <= {LC_W{1'b0}};
         lock_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         lock_q <= lock_d;
      end
   end
`else
   logic lock_q;
   assign lock_q = 1'b0;
`endif

   assign pfd_if.o_up        = up_q;
   assign pfd_if.o_down      = down_q;
   assign pfd_if.o_err       = err_q;
   assign pfd_if.o_err_valid = err_valid_q;
   assign pfd_if.o_slip      = slip_q;
   assign pfd_if.o_lock      = lock_q;
   assign pfd_if.o_scan_out  = div_ch_q[CH_W-1];

endmodule

// File: doc/tt_pfd_tdc.md
Name: tt_pfd_tdc

Overview:
Parametrised digital phase-frequency detector with integrated time-to-digital error measurement, the next generation of the PLL phase detector. It synchronises i_clk_ref and i_clk_div into the i_clk_gen domain and detects rising edges. A three-state UP/DOWN/IDLE machine drives registered charge-pump-style o_up/o_down and emits a signed, saturating phase error in i_clk_gen cycles for the digital loop filter. It also flags cycle slips and keeps the scan-chain interface.

Parameters:
SYNC_STAGES, 2, synchroniser depth per input (>=2)
ERR_W, 8, width of signed phase-error output (>=4)
LOCK_TOL, 1, max |error| counted as in-lock (lock detector only)
LOCK_COUNT, 16, consecutive in-tolerance measurements needed for lock (lock detector only)

Ports:
i_clk_gen  in  1  system/sample clock
i_rst_n  in  1  reset, synchronous, active-low
i_clk_ref  in  1  reference clock (asynchronous)
i_clk_div  in  1  divided feedback clock (asynchronous)
o_up  out  1  registered; high while ref leads
o_down  out  1  registered; high while div leads
o_err  out  ERR_W  signed phase error, two's complement; +ref leads, -div leads
o_err_valid  out  1  one-cycle strobe qualifying o_err
o_slip  out  1  one-cycle cycle-slip strobe
o_lock  out  1  lock indicator
i_scan_en  in  1  scan shift enable
i_scan_in  in  1  scan data in
o_scan_out  out  1  scan data out

Behaviour:
- Reset: synchronous, active-low, priority over scan. Clears all flops. State=IDLE; o_up, o_down, o_err, o_err_valid, o_slip, o_lock all 0.
- Sync: each input feeds SYNC_STAGES flops plus one history flop (SYNC_STAGES+1 per input).
  - edge = last sync stage & !history.
  - Input rise to edge detect: SYNC_STAGES+1 cycles.
- cnt: unsigned ERR_W-1 bits, saturates at 2^(ERR_W-1)-1 (127 for ERR_W=8); never wraps.
- IDLE:
  - ref_edge only -> UP, cnt<=1.
  - div_edge only -> DOWN, cnt<=1.
  - both -> stay IDLE; o_err_valid=1, o_err=0.
- UP:
  - no edge -> cnt<=sat(cnt+1).
  - div_edge only -> IDLE; o_err_valid=1, o_err=+cnt.
  - ref_edge only -> stay UP; o_slip=1; cnt keeps counting.
  - both -> o_err_valid with +cnt, stay UP, cnt<=1 (new measurement opens).
- DOWN: mirror of UP with ref/div swapped; error emitted as -cnt.
- Error output timing:
  - o_up = (state==UP), o_down = (state==DOWN), registered; never both 1.
  - o_err/o_err_valid/o_slip registered, asserted the cycle after the closing edge. o_err holds its last value while o_err_valid=0.
  - Error magnitude = cycles between ref and div edge detections.
- Scan (i_scan_en=1, reset deasserted):
  - Chain order: i_scan_in -> ref sync stages -> ref history -> div sync stages -> div history -> o_scan_out.
  - Length 2*(SYNC_STAGES+1).
  - Edges masked; state, cnt, o_up, o_down, o_err, o_lock hold; strobes 0.
  - On scan exit, history flops hold scanned data. Spurious edges are possible and accepted.
- Reset mid-measurement: discards it with no o_err_valid.

Optional Feature:
TT_PFD_LOCK_DET_EN
- Defined:
  - Counter of consecutive o_err_valid strobes with |o_err|<=LOCK_TOL; saturates at LOCK_COUNT.
  - o_lock=1 when count==LOCK_COUNT.
  - An out-of-tolerance strobe or o_slip clears count and o_lock on the next cycle.
- Undefined: o_lock tied 0; no counter logic.

Test Plan:
Default params. Edge gaps below are measured at the detector.
1. Basic lead: ref edge, div edge 5 cycles later -> o_up high 5 cycles; o_err_valid pulse with o_err=+5; o_down stays 0.
2. Basic lag: div leads by 3 cycles -> o_down high 3 cycles; o_err=-3 (8'hFD).
3. Same-cycle edges, from IDLE and from inside UP -> IDLE case: o_err=0, no o_up/o_down. UP case: previous error emitted, new UP opened with cnt=1.
4. Slip and saturation: two ref edges, no div, then div 200 cycles after first ref -> o_slip pulse on second ref edge; o_err=+127.
5. Scan: i_scan_en=1, shift 101101 -> bits appear on o_scan_out in order after 6 cycles. State and outputs unchanged during shift. Reset asserted during scan clears chain to 0.
6. Lock (macro on, LOCK_COUNT=4, LOCK_TOL=1): errors +1,-1,0,+1 -> o_lock rises after 4th strobe. Next error +5 -> o_lock cleared. Macro off -> o_lock constant 0.
